// File: rtl/cpunc_axi_pkg.sv
// Shared constants and state encodings for the CPUNC single-beat AXI memory slave.
package cpunc_axi_pkg;

   localparam logic       RESP_OKAY = 1'b0;
   localparam logic       RESP_ERR  = 1'b1;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic {
      W_IDLE,
      W_RESP
   } wstate_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_RESP
   } rstate_t;

endpackage

// File: rtl/cpunc_mem_array.sv
// Word-organised RAM with a byte-enabled synchronous write port and an asynchronous read port.
module cpunc_mem_array #(
   parameter int unsigned IDX_W  = 10,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  CPUNC_ACLK,
   input  logic                  we,
   input  logic [IDX_W-1:0]      widx,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   input  logic [IDX_W-1:0]      ridx,
   output logic [DATA_W-1:0]     rdata_c
);

   localparam int unsigned DEPTH  = 1 << IDX_W;
   localparam int unsigned BYTE_N = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];

   // Byte-lane write; contents are intentionally left untouched by reset.
   always_ff @(posedge CPUNC_ACLK) begin
      if (we) begin
         for (int b = 0; b < BYTE_N; b++) begin
            if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata_c = mem[ridx];

endmodule

// File: rtl/cpunc_axi_mem_slave.sv
// Single-beat AXI slave memory: independent write (AW+W->B) and read (AR->R) channels
// with a programmable read latency.
module cpunc_axi_mem_slave
   import cpunc_axi_pkg::*;
#(
   parameter int unsigned MEM_POWER_SIZE = 12,
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned AXI_ADDR_WIDTH = MEM_POWER_SIZE,
   parameter int unsigned RD_LATENCY     = 1
) (
   input  logic                        CPUNC_ACLK,
   input  logic                        CPUNC_ARESETn,
   input  logic [7:0]                  CPUNC_AWID,
   input  logic [AXI_ADDR_WIDTH-1:0]   CPUNC_AWADDR,
   input  logic [1:0]                  CPUNC_AWSIZE,
   input  logic                        CPUNC_AWVALID,
   output logic                        CPUNC_AWREADY,
   input  logic [AXI_DATA_WIDTH-1:0]   CPUNC_WDATA,
   input  logic [AXI_DATA_WIDTH/8-1:0] CPUNC_WSTRB,
   input  logic                        CPUNC_WLAST,
   input  logic                        CPUNC_WVALID,
   output logic                        CPUNC_WREADY,
   output logic [7:0]                  CPUNC_BID,
   output logic                        CPUNC_BRESP,
   output logic                        CPUNC_BVALID,
   input  logic                        CPUNC_BREADY,
   input  logic [7:0]                  CPUNC_ARID,
   input  logic [AXI_ADDR_WIDTH-1:0]   CPUNC_ARADDR,
   input  logic [1:0]                  CPUNC_ARSIZE,
   input  logic                        CPUNC_ARVALID,
   output logic                        CPUNC_ARREADY,
   output logic [7:0]                  CPUNC_RID,
   output logic [AXI_DATA_WIDTH-1:0]   CPUNC_RDATA,
   output logic                        CPUNC_RRESP,
   output logic                        CPUNC_RLAST,
   output logic                        CPUNC_RVALID,
   input  logic                        CPUNC_RREADY
);

   localparam int unsigned IDX_W  = AXI_ADDR_WIDTH - 2;
   localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
   localparam logic [3:0]  LAT_LAST = (RD_LATENCY == 0) ? 4'd0 : 4'(RD_LATENCY - 1);

   // Write-side holding registers
   wstate_t                  wstate;
   logic                     aw_held;
   logic [7:0]               aw_id;
   logic [IDX_W-1:0]         aw_idx;
   logic [1:0]               aw_size;
   logic                     w_held;
   logic [AXI_DATA_WIDTH-1:0] w_data;
   logic [STRB_W-1:0]        w_strb;
   logic                     w_last;

   // Read-side holding registers
   rstate_t                  rstate;
   logic [3:0]               r_cnt;
   logic [7:0]               ar_id;
   logic [IDX_W-1:0]         ar_idx;
   logic                     ar_err;

   logic                     aw_fire_c;
   logic                     w_fire_c;
   logic [7:0]               cur_awid_c;
   logic [IDX_W-1:0]         cur_awidx_c;
   logic [1:0]               cur_awsize_c;
   logic [AXI_DATA_WIDTH-1:0] cur_wdata_c;
   logic [STRB_W-1:0]        cur_wstrb_c;
   logic                     cur_wlast_c;
   logic                     commit_c;
   logic                     wr_err_c;
   logic                     mem_we_c;
   logic                     ar_fire_c;
   logic                     ar_err_in_c;
   logic [IDX_W-1:0]         rd_idx_c;
   logic [AXI_DATA_WIDTH-1:0] mem_rdata_c;
   logic                     unused_addr_bits_c;

   assign unused_addr_bits_c = ^{CPUNC_AWADDR[1:0], CPUNC_ARADDR[1:0]};

   // Merge held and incoming AW/W so a commit can use either source in the same cycle.
   always_comb begin
      aw_fire_c    = CPUNC_AWVALID && CPUNC_AWREADY;
      w_fire_c     = CPUNC_WVALID && CPUNC_WREADY;
      cur_awid_c   = aw_held ? aw_id   : CPUNC_AWID;
      cur_awidx_c  = aw_held ? aw_idx  : CPUNC_AWADDR[AXI_ADDR_WIDTH-1:2];
      cur_awsize_c = aw_held ? aw_size : CPUNC_AWSIZE;
      cur_wdata_c  = w_held  ? w_data  : CPUNC_WDATA;
      cur_wstrb_c  = w_held  ? w_strb  : CPUNC_WSTRB;
      cur_wlast_c  = w_held  ? w_last  : CPUNC_WLAST;
      commit_c     = (wstate == W_IDLE) && (aw_held || aw_fire_c) && (w_held || w_fire_c);
      wr_err_c     = (cur_awsize_c != SIZE_WORD) || !cur_wlast_c;
      mem_we_c     = commit_c && !wr_err_c && !CPUNC_ARESETn;
      ar_fire_c    = CPUNC_ARVALID && CPUNC_ARREADY;
      ar_err_in_c  = (CPUNC_ARSIZE != SIZE_WORD);
      rd_idx_c     = (rstate == R_IDLE) ? CPUNC_ARADDR[AXI_ADDR_WIDTH-1:2] : ar_idx;
   end

   cpunc_mem_array #(
      .IDX_W  (IDX_W),
      .DATA_W (AXI_DATA_WIDTH)
   ) u_mem (
      .CPUNC_ACLK (CPUNC_ACLK),
      .we         (mem_we_c),
      .widx       (cur_awidx_c),
      .wdata      (cur_wdata_c),
      .wstrb      (cur_wstrb_c),
      .ridx       (rd_idx_c),
      .rdata_c    (mem_rdata_c)
   );

   // Write FSM: capture AW/W independently, commit when both are present, hold B until accepted.
   always_ff @(posedge CPUNC_ACLK or posedge CPUNC_ARESETn) begin
      if (CPUNC_ARESETn) begin
         wstate        <= W_IDLE;
         aw_held       <= 1'b0;
         aw_id         <= '0;
         aw_idx        <= '0;
         aw_size       <= '0;
         w_held        <= 1'b0;
         w_data        <= '0;
         w_strb        <= '0;
         w_last        <= 1'b0;
         CPUNC_AWREADY <= 1'b1;
         CPUNC_WREADY  <= 1'b1;
         CPUNC_BVALID  <= 1'b0;
         CPUNC_BID     <= '0;
         CPUNC_BRESP   <= RESP_OKAY;
      end else begin
         case (wstate)
            W_IDLE: begin
               if (commit_c) begin
                  wstate        <= W_RESP;
                  aw_held       <= 1'b1;
                  w_held        <= 1'b1;
                  CPUNC_AWREADY <= 1'b0;
                  CPUNC_WREADY  <= 1'b0;
                  CPUNC_BVALID  <= 1'b1;
                  CPUNC_BID     <= cur_awid_c;
                  CPUNC_BRESP   <= wr_err_c ? RESP_ERR : RESP_OKAY;
               end else begin
                  if (aw_fire_c) begin
                     aw_held       <= 1'b1;
                     aw_id         <= CPUNC_AWID;
                     aw_idx        <= CPUNC_AWADDR[AXI_ADDR_WIDTH-1:2];
                     aw_size       <= CPUNC_AWSIZE;
                     CPUNC_AWREADY <= 1'b0;
                  end
                  if (w_fire_c) begin
                     w_held       <= 1'b1;
                     w_data       <= CPUNC_WDATA;
                     w_strb       <= CPUNC_WSTRB;
                     w_last       <= CPUNC_WLAST;
                     CPUNC_WREADY <= 1'b0;
                  end
               end
            end
            W_RESP: begin
               if (CPUNC_BREADY) begin
                  wstate        <= W_IDLE;
                  aw_held       <= 1'b0;
                  w_held        <= 1'b0;
                  CPUNC_AWREADY <= 1'b1;
                  CPUNC_WREADY  <= 1'b1;
                  CPUNC_BVALID  <= 1'b0;
               end
            end
            default: wstate <= W_IDLE;
         endcase
      end
   end

   // Read FSM: accept AR, wait RD_LATENCY cycles, sample RAM on entry to R_RESP, hold R until accepted.
   always_ff @(posedge CPUNC_ACLK or posedge CPUNC_ARESETn) begin
      if (CPUNC_ARESETn) begin
         rstate        <= R_IDLE;
         r_cnt         <= '0;
         ar_id         <= '0;
         ar_idx        <= '0;
         ar_err        <= 1'b0;
         CPUNC_ARREADY <= 1'b1;
         CPUNC_RVALID  <= 1'b0;
         CPUNC_RLAST   <= 1'b0;
         CPUNC_RRESP   <= RESP_OKAY;
         CPUNC_RID     <= '0;
         CPUNC_RDATA   <= '0;
      end else begin
         case (rstate)
            R_IDLE: begin
               if (ar_fire_c) begin
                  ar_id         <= CPUNC_ARID;
                  ar_idx        <= CPUNC_ARADDR[AXI_ADDR_WIDTH-1:2];
                  ar_err        <= ar_err_in_c;
                  r_cnt         <= '0;
                  CPUNC_ARREADY <= 1'b0;
                  if (RD_LATENCY == 0) begin
                     rstate       <= R_RESP;
                     CPUNC_RVALID <= 1'b1;
                     CPUNC_RLAST  <= 1'b1;
                     CPUNC_RID    <= CPUNC_ARID;
                     CPUNC_RRESP  <= ar_err_in_c ? RESP_ERR : RESP_OKAY;
                     CPUNC_RDATA  <= ar_err_in_c ? '0 : mem_rdata_c;
                  end else begin
                     rstate <= R_WAIT;
                  end
               end
            end
            R_WAIT: begin
               if (r_cnt == LAT_LAST) begin
                  rstate       <= R_RESP;
                  CPUNC_RVALID <= 1'b1;
                  CPUNC_RLAST  <= 1'b1;
                  CPUNC_RID    <= ar_id;
                  CPUNC_RRESP  <= ar_err ? RESP_ERR : RESP_OKAY;
                  CPUNC_RDATA  <= ar_err ? '0 : mem_rdata_c;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            R_RESP: begin
               if (CPUNC_RREADY) begin
                  rstate        <= R_IDLE;
                  CPUNC_ARREADY <= 1'b1;
                  CPUNC_RVALID  <= 1'b0;
                  CPUNC_RLAST   <= 1'b0;
                  CPUNC_RDATA   <= '0;
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpunc_axi_mem_slave.sv
// Directed scoreboard bench: instance 0 uses RD_LATENCY=3, instance 1 uses RD_LATENCY=0.
module tb_cpunc_axi_mem_slave;

   typedef struct packed {
      logic [7:0]  id;
      logic        resp;
      logic [31:0] data;
   } rexp_t;

   typedef struct packed {
      logic [7:0] id;
      logic       resp;
   } bexp_t;

   logic        clk;
   logic        rst;
   logic [7:0]  awid    [2];
   logic [11:0] awaddr  [2];
   logic [1:0]  awsize  [2];
   logic        awvalid [2];
   logic        awready [2];
   logic [31:0] wdata   [2];
   logic [3:0]  wstrb   [2];
   logic        wlast   [2];
   logic        wvalid  [2];
   logic        wready  [2];
   logic [7:0]  bid     [2];
   logic        bresp   [2];
   logic        bvalid  [2];
   logic        bready  [2];
   logic [7:0]  arid    [2];
   logic [11:0] araddr  [2];
   logic [1:0]  arsize  [2];
   logic        arvalid [2];
   logic        arready [2];
   logic [7:0]  rid     [2];
   logic [31:0] rdata   [2];
   logic        rresp   [2];
   logic        rlast   [2];
   logic        rvalid  [2];
   logic        rready  [2];

   logic [31:0] model [2][1024];
   rexp_t       rq [$];
   bexp_t       bq [$];
   int          total = 0;
   int          bad   = 0;

   cpunc_axi_mem_slave #(.MEM_POWER_SIZE(12), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(12), .RD_LATENCY(3)) dut_l3 (
      .CPUNC_ACLK(clk), .CPUNC_ARESETn(rst),
      .CPUNC_AWID(awid[0]), .CPUNC_AWADDR(awaddr[0]), .CPUNC_AWSIZE(awsize[0]),
      .CPUNC_AWVALID(awvalid[0]), .CPUNC_AWREADY(awready[0]),
      .CPUNC_WDATA(wdata[0]), .CPUNC_WSTRB(wstrb[0]), .CPUNC_WLAST(wlast[0]),
      .CPUNC_WVALID(wvalid[0]), .CPUNC_WREADY(wready[0]),
      .CPUNC_BID(bid[0]), .CPUNC_BRESP(bresp[0]), .CPUNC_BVALID(bvalid[0]), .CPUNC_BREADY(bready[0]),
      .CPUNC_ARID(arid[0]), .CPUNC_ARADDR(araddr[0]), .CPUNC_ARSIZE(arsize[0]),
      .CPUNC_ARVALID(arvalid[0]), .CPUNC_ARREADY(arready[0]),
      .CPUNC_RID(rid[0]), .CPUNC_RDATA(rdata[0]), .CPUNC_RRESP(rresp[0]),
      .CPUNC_RLAST(rlast[0]), .CPUNC_RVALID(rvalid[0]), .CPUNC_RREADY(rready[0])
   );

   cpunc_axi_mem_slave #(.MEM_POWER_SIZE(12), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(12), .RD_LATENCY(0)) dut_l0 (
      .CPUNC_ACLK(clk), .CPUNC_ARESETn(rst),
      .CPUNC_AWID(awid[1]), .CPUNC_AWADDR(awaddr[1]), .CPUNC_AWSIZE(awsize[1]),
      .CPUNC_AWVALID(awvalid[1]), .CPUNC_AWREADY(awready[1]),
      .CPUNC_WDATA(wdata[1]), .CPUNC_WSTRB(wstrb[1]), .CPUNC_WLAST(wlast[1]),
      .CPUNC_WVALID(wvalid[1]), .CPUNC_WREADY(wready[1]),
      .CPUNC_BID(bid[1]), .CPUNC_BRESP(bresp[1]), .CPUNC_BVALID(bvalid[1]), .CPUNC_BREADY(bready[1]),
      .CPUNC_ARID(arid[1]), .CPUNC_ARADDR(araddr[1]), .CPUNC_ARSIZE(arsize[1]),
      .CPUNC_ARVALID(arvalid[1]), .CPUNC_ARREADY(arready[1]),
      .CPUNC_RID(rid[1]), .CPUNC_RDATA(rdata[1]), .CPUNC_RRESP(rresp[1]),
      .CPUNC_RLAST(rlast[1]), .CPUNC_RVALID(rvalid[1]), .CPUNC_RREADY(rready[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int lat(input int d);
      return (d == 0) ? 3 : 0;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input int d);
      check("reset_ctl", {awready[d], wready[d], arready[d], bvalid[d], rvalid[d],
                          bresp[d], rresp[d], rlast[d], bid[d], rid[d]},
            {3'b111, 5'b00000, 8'h00, 8'h00});
      check("reset_rdata", rdata[d], 32'h0);
   endtask

   task automatic do_write(input int d, input logic [11:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] size, input logic last,
                           input logic [7:0] id, input int w_lead, input int b_hold);
      logic  err;
      logic  aw_pend, w_pend, aw_hs, w_hs;
      bexp_t e;
      int    n;
      err = (size != 2'b10) || !last;
      bq.push_back('{id: id, resp: err});
      if (!err) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) model[d][addr[11:2]][8*b +: 8] = data[8*b +: 8];
      end
      awaddr[d] = addr; awid[d] = id; awsize[d] = size;
      wdata[d] = data; wstrb[d] = strb; wlast[d] = last;
      aw_pend = 1'b1; w_pend = 1'b1; n = 0;
      while ((aw_pend || w_pend) && n < 20) begin
         awvalid[d] = aw_pend && (n >= w_lead);
         wvalid[d]  = w_pend;
         if (n > 0) check("b_before_commit", bvalid[d], 1'b0);
         aw_hs = awvalid[d] && awready[d];
         w_hs  = wvalid[d] && wready[d];
         tick();
         if (aw_hs) aw_pend = 1'b0;
         if (w_hs)  w_pend  = 1'b0;
         n++;
      end
      awvalid[d] = 1'b0; wvalid[d] = 1'b0;
      check("wr_handshake", {aw_pend, w_pend}, 2'b00);
      check("bvalid_latency", bvalid[d], 1'b1);
      e = bq.pop_front();
      check("bid", bid[d], e.id);
      check("bresp", bresp[d], e.resp);
      for (int i = 0; i < b_hold; i++) begin
         check("aw_w_busy", {awready[d], wready[d]}, 2'b00);
         tick();
         check("b_stable", {bvalid[d], bid[d], bresp[d]}, {1'b1, e.id, e.resp});
      end
      bready[d] = 1'b1;
      tick();
      bready[d] = 1'b0;
      check("b_done", {bvalid[d], awready[d], wready[d]}, 3'b011);
   endtask

   task automatic do_read(input int d, input logic [11:0] addr, input logic [1:0] size,
                          input logic [7:0] id, input int r_hold);
      logic  err;
      rexp_t e;
      int    n;
      err = (size != 2'b10);
      rq.push_back('{id: id, resp: err, data: (err ? 32'h0 : model[d][addr[11:2]])});
      araddr[d] = addr; arid[d] = id; arsize[d] = size; arvalid[d] = 1'b1;
      n = 0;
      while (!arready[d] && n < 20) begin
         tick();
         n++;
      end
      check("ar_ready", arready[d], 1'b1);
      tick();
      arvalid[d] = 1'b0;
      n = 0;
      while (!rvalid[d] && n < 40) begin
         check("ar_busy", arready[d], 1'b0);
         tick();
         n++;
      end
      check("r_latency", n, lat(d));
      check("rlast", rlast[d], 1'b1);
      e = rq.pop_front();
      check("rid", rid[d], e.id);
      check("rdata", rdata[d], e.data);
      check("rresp", rresp[d], e.resp);
      for (int i = 0; i < r_hold; i++) begin
         tick();
         check("r_stable", {rvalid[d], rlast[d], rid[d], rresp[d], rdata[d]},
               {1'b1, 1'b1, e.id, e.resp, e.data});
      end
      rready[d] = 1'b1;
      tick();
      rready[d] = 1'b0;
      check("r_done", {rvalid[d], rlast[d], rdata[d], arready[d]}, {2'b00, 32'h0, 1'b1});
   endtask

   initial begin
      rexp_t re;
      bexp_t be;
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         awid[d] = '0; awaddr[d] = '0; awsize[d] = 2'b10; awvalid[d] = 1'b0;
         wdata[d] = '0; wstrb[d] = '0; wlast[d] = 1'b1; wvalid[d] = 1'b0; bready[d] = 1'b0;
         arid[d] = '0; araddr[d] = '0; arsize[d] = 2'b10; arvalid[d] = 1'b0; rready[d] = 1'b0;
      end
      tick(); tick(); tick();
      check_reset(0);
      check_reset(1);
      rst = 1'b0;
      tick();

      // full-word write then read back
      do_write(0, 12'h010, 32'hDEADBEEF, 4'b1111, 2'b10, 1'b1, 8'h11, 0, 0);
      do_read (0, 12'h010, 2'b10, 8'h22, 0);

      // single byte lane merge
      do_write(0, 12'h010, 32'h000000AA, 4'b0001, 2'b10, 1'b1, 8'h12, 0, 0);
      do_read (0, 12'h010, 2'b10, 8'h23, 2);

      // W leads AW by two cycles, B held off for three cycles
      do_write(0, 12'h014, 32'h01020304, 4'b1111, 2'b10, 1'b1, 8'h33, 2, 3);
      do_write(0, 12'h014, 32'hA0B0C0D0, 4'b0110, 2'b10, 1'b1, 8'h34, 1, 1);
      do_read (0, 12'h014, 2'b10, 8'h35, 0);

      // error write/read leave RAM untouched
      do_write(0, 12'h020, 32'h0A0B0C0D, 4'b1111, 2'b10, 1'b1, 8'h40, 0, 0);
      do_write(0, 12'h020, 32'h12345678, 4'b1111, 2'b01, 1'b1, 8'h44, 0, 0);
      do_write(0, 12'h020, 32'hFFFFFFFF, 4'b1111, 2'b10, 1'b0, 8'h45, 0, 0);
      do_read (0, 12'h020, 2'b01, 8'h55, 1);
      do_read (0, 12'h020, 2'b10, 8'h56, 0);

      // zero-latency instance: read and write of the same word in the same edge
      do_write(1, 12'h030, 32'h11223344, 4'b1111, 2'b10, 1'b1, 8'h01, 0, 0);
      do_read (1, 12'h030, 2'b10, 8'h02, 0);
      rq.push_back('{id: 8'h66, resp: 1'b0, data: model[1][12]});
      bq.push_back('{id: 8'h77, resp: 1'b0});
      araddr[1] = 12'h030; arid[1] = 8'h66; arsize[1] = 2'b10; arvalid[1] = 1'b1;
      awaddr[1] = 12'h030; awid[1] = 8'h77; awsize[1] = 2'b10; awvalid[1] = 1'b1;
      wdata[1] = 32'h00000055; wstrb[1] = 4'b1111; wlast[1] = 1'b1; wvalid[1] = 1'b1;
      check("col_ready", {arready[1], awready[1], wready[1]}, 3'b111);
      tick();
      arvalid[1] = 1'b0; awvalid[1] = 1'b0; wvalid[1] = 1'b0;
      model[1][12] = 32'h00000055;
      re = rq.pop_front();
      be = bq.pop_front();
      check("col_valid", {rvalid[1], bvalid[1]}, 2'b11);
      check("col_rdata_old", {rid[1], rresp[1], rdata[1]}, {re.id, re.resp, re.data});
      check("col_b", {bid[1], bresp[1]}, {be.id, be.resp});
      rready[1] = 1'b1; bready[1] = 1'b1;
      tick();
      rready[1] = 1'b0; bready[1] = 1'b0;
      check("col_done", {rvalid[1], bvalid[1]}, 2'b00);
      do_read (1, 12'h030, 2'b10, 8'h68, 0);

      // reset while read is waiting and only AW is held
      do_write(0, 12'h040, 32'hCAFEF00D, 4'b1111, 2'b10, 1'b1, 8'h70, 0, 0);
      araddr[0] = 12'h040; arid[0] = 8'h88; arsize[0] = 2'b10; arvalid[0] = 1'b1;
      tick();
      arvalid[0] = 1'b0;
      awaddr[0] = 12'h040; awid[0] = 8'h99; awsize[0] = 2'b10; awvalid[0] = 1'b1;
      wdata[0] = 32'h0BAD0BAD; wstrb[0] = 4'b1111;
      tick();
      awvalid[0] = 1'b0;
      check("pre_reset", {awready[0], wready[0], arready[0], rvalid[0], bvalid[0]}, 5'b01000);
      rst = 1'b1;
      #1;
      check_reset(0);
      check_reset(1);
      tick();
      rst = 1'b0;
      tick();
      do_read (0, 12'h040, 2'b10, 8'h89, 0);
      do_write(0, 12'h044, 32'h5A5A1234, 4'b1111, 2'b10, 1'b1, 8'h9A, 0, 0);
      do_read (0, 12'h044, 2'b10, 8'h9B, 0);
      do_read (0, 12'h040, 2'b10, 8'h9C, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
